rr_arb8: RTL and testbench
==========================

RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum number of consecutive cycles one requester may hold a grant (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  arbiter enable; gates new grants only.
REQ-005 req  input  8  request lines; bit k is requester k.
REQ-006 done  input  1  owner signals end of transfer; sampled only in GRANT.
REQ-007 gnt  output  8  one-hot grant, registered.
REQ-008 gnt_idx  output  3  binary index of the grant owner, registered.
REQ-009 gnt_vld  output  1  high exactly when gnt is non-zero.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with en=1 and req!=0, the next edge SHALL enter GRANT and grant the first set req bit searching ptr, ptr+1, ... 7, 0, ... ptr-1.
REQ-012 Grant latency SHALL be exactly 1 cycle from the sampled req to gnt/gnt_vld high.
REQ-013 In IDLE with en=0 or req=0, outputs SHALL stay zero and ptr SHALL be unchanged.
REQ-014 In GRANT, gnt, gnt_idx and gnt_vld SHALL be stable until release.
REQ-015 Release SHALL occur at the edge where any of the following is sampled: done=1, req[owner]=0, or hold_cnt=MAX_HOLD-1.
REQ-016 hold_cnt SHALL be 0 in the first GRANT cycle and SHALL increment by 1 per GRANT cycle.
REQ-017 On release, the FSM SHALL return to IDLE, clear gnt/gnt_idx/gnt_vld, set ptr to owner+1 modulo 8 (7 wraps to 0), and clear hold_cnt.
REQ-018 There SHALL be at least one IDLE cycle (gnt_vld=0) between any two grants.
REQ-019 Deasserting en during GRANT SHALL NOT revoke the current grant.
REQ-020 Changes on non-owner req bits during GRANT SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 gnt_idx SHALL equal the encoded gnt when gnt_vld=1, and 3'd0 otherwise.

Reset
REQ-023 While rst=1, asynchronously: state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=3'd0, gnt_vld=0.
REQ-024 Asserting rst mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-025 The first arbitration after rst release SHALL start its search at requester 0.

Structure
REQ-026 Shared package arb_pkg SHALL hold the state typedef (IDLE, GRANT), NREQ=8 and IDX_W=3.
REQ-027 The search SHALL be a sub-module prio_enc8: an 8-to-3 combinational priority encoder with a valid output, applied to req rotated by ptr; its result SHALL be added to ptr modulo 8.
REQ-028 The block SHALL contain no other sub-modules and no latches.

Verification
REQ-029 Single request: after reset, en=1, req=8'b0000_0001 -> next cycle gnt=8'b0000_0001, gnt_idx=0, gnt_vld=1.
REQ-030 Rotation and wrap: req=8'hFF held, done pulsed in each grant cycle -> gnt_idx sequence 0,1,2,...,7,0, with one gnt_vld=0 cycle between grants.
REQ-031 Timeout: MAX_HOLD=16, req=8'b0000_0011, owner 0 holds with done=0 -> gnt_vld high for exactly 16 cycles, one idle cycle, then gnt_idx=1.
REQ-032 Pointer fairness: after owner 5 releases, req=8'b0010_0101 -> next grant gnt_idx=0 (search order 6,7,0), then 2, then 5.
REQ-033 Reset mid-grant: rst asserted between edges during a grant -> gnt=0 and gnt_vld=0 immediately; after release, req=8'b0010_0100 -> gnt_idx=2.
REQ-034 Enable: en=0 with req=8'hFF -> no grant for 10 cycles; en dropped during a grant -> grant held until done=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned NREQ  = 8;
   localparam int unsigned IDX_W = 3;

   // Arbiter FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage : arb_pkg

// File: rtl/prio_enc8.sv
// 8-to-3 priority encoder: lowest set bit wins; vld_o flags a non-zero input.
module prio_enc8
   import arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);

   // Scan from the top down so the lowest set bit is the last one written
   always_comb begin
      idx_o = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
      vld_o = |req_i;
   end

endmodule : prio_enc8

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// A grant lasts until the owner signals done, drops its request, or hits
// MAX_HOLD cycles; an idle cycle always separates consecutive grants.
module rr_arb8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NREQ-1:0]  req,
   input  logic             done,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   localparam int unsigned HOLD_W = 8;
   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [HOLD_W-1:0] hold_q;
   logic [NREQ-1:0]   gnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              vld_q;

   logic [NREQ-1:0]   req_rot;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_vld;
   logic [IDX_W-1:0]  win_idx;
   logic              release_grant;

   // Rotate requests so that requester ptr_q lands at bit 0
   always_comb begin
      req_rot = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_rot[i] = req[IDX_W'(i) + ptr_q];
      end
   end

   prio_enc8 u_prio_enc8 (
      .req_i (req_rot),
      .idx_o (enc_idx),
      .vld_o (enc_vld)
   );

   // Undo the rotation (3-bit add wraps modulo 8) and evaluate release terms
   always_comb begin
      win_idx       = enc_idx + ptr_q;
      release_grant = done || !req[idx_q] || (hold_q == HoldLast);
   end

   // Arbiter FSM with registered grant outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en && enc_vld) begin
                  state_q <= GRANT;
                  gnt_q   <= NREQ'(1) << win_idx;
                  idx_q   <= win_idx;
                  vld_q   <= 1'b1;
                  hold_q  <= '0;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  state_q <= IDLE;
                  gnt_q   <= '0;
                  idx_q   <= '0;
                  vld_q   <= 1'b0;
                  ptr_q   <= idx_q + 1'b1;
                  hold_q  <= '0;
               end else begin
                  hold_q  <= hold_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;

endmodule : rr_arb8

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with a queue of expected output triples.
module tb_rr_arb8;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      string      tag;
   } exp_t;

   exp_t sb[$];

   rr_arb8 #(.MAX_HOLD(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic push_grant(input int k, input string tag);
      exp_t e;
      e.gnt = 8'd1 << k;
      e.idx = 3'(k);
      e.vld = 1'b1;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic push_idle(input string tag);
      exp_t e;
      e.gnt = 8'h00;
      e.idx = 3'd0;
      e.vld = 1'b0;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: got gnt=%h idx=%0d vld=%b, expected an entry",
                gnt, gnt_idx, gnt_vld);
      end else begin
         e = sb.pop_front();
         assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt: got %h expected %h", e.tag, gnt, e.gnt);
         end
         checks++;
         assert (gnt_idx === e.idx) else begin
            errors++;
            $error("FAIL %s gnt_idx: got %0d expected %0d", e.tag, gnt_idx, e.idx);
         end
         checks++;
         assert (gnt_vld === e.vld) else begin
            errors++;
            $error("FAIL %s gnt_vld: got %b expected %b", e.tag, gnt_vld, e.vld);
         end
      end
   endtask

   // Advance one clock and compare just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Pulse reset between edges; outputs must clear without a clock
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      push_idle(tag);
      check_out();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      req  = 8'h00;
      done = 1'b0;
      #2;
      push_idle("reset_state");
      check_out();
      @(posedge clk);
      #1;
      do_reset("reset_again");

      // Single request
      en  = 1'b1;
      req = 8'b0000_0001;
      push_grant(0, "single_req");
      tick();
      done = 1'b1;
      push_idle("single_release");
      tick();
      done = 1'b0;
      req  = 8'h00;

      // Rotation and wrap with all requesters active
      do_reset("reset_rot");
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         push_grant(i % 8, $sformatf("rot_grant%0d", i));
         tick();
         done = 1'b1;
         push_idle($sformatf("rot_gap%0d", i));
         tick();
         done = 1'b0;
      end
      req = 8'h00;

      // Timeout after MAX_HOLD cycles
      do_reset("reset_timeout");
      req = 8'b0000_0011;
      for (int i = 0; i < 16; i++) begin
         push_grant(0, $sformatf("hold_cycle%0d", i));
         tick();
      end
      push_idle("timeout_release");
      tick();
      push_grant(1, "after_timeout");
      tick();
      req  = 8'h00;
      push_idle("drop_req_release");
      tick();

      // Pointer fairness after owner 5
      do_reset("reset_fair");
      req = 8'b0010_0000;
      push_grant(5, "owner5");
      tick();
      req = 8'h00;
      push_idle("owner5_release");
      tick();
      req = 8'b0010_0101;
      push_grant(0, "fair_first");
      tick();
      done = 1'b1;
      push_idle("fair_gap0");
      tick();
      done = 1'b0;
      push_grant(2, "fair_second");
      tick();
      done = 1'b1;
      push_idle("fair_gap1");
      tick();
      done = 1'b0;
      push_grant(5, "fair_third");
      tick();
      done = 1'b1;
      push_idle("fair_gap2");
      tick();
      done = 1'b0;
      req  = 8'h00;

      // Reset in the middle of a grant
      do_reset("reset_mid_pre");
      req = 8'b0000_0001;
      push_grant(0, "mid_grant");
      tick();
      #3;
      do_reset("reset_mid_drop");
      req = 8'b0010_0100;
      push_grant(2, "after_mid_reset");
      tick();
      done = 1'b1;
      push_idle("after_mid_release");
      tick();
      done = 1'b0;
      req  = 8'h00;

      // Enable gating and non-owner request changes
      do_reset("reset_en");
      en  = 1'b0;
      req = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         push_idle($sformatf("en_off%0d", i));
         tick();
      end
      en = 1'b1;
      push_grant(0, "en_on_grant");
      tick();
      en  = 1'b0;
      req = 8'h81;
      for (int i = 0; i < 3; i++) begin
         push_grant(0, $sformatf("en_drop_hold%0d", i));
         tick();
      end
      req = 8'h7D;
      push_grant(0, "nonowner_change");
      tick();
      done = 1'b1;
      push_idle("en_drop_release");
      tick();
      done = 1'b0;
      push_idle("en_off_after");
      tick();
      push_idle("en_off_after2");
      tick();

      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_rr_arb8
